// File: rtl/ysyx_22050550_trap_seq.sv
// Timer-interrupt trap sequencer and CSR write-port arbiter.
// Sits between write-back and the CSR file. When a machine timer interrupt is
// pending and enabled, it freezes fetch, drains the pipeline, takes the CSR
// write port for one cycle to write mepc/mcause/mstatus, then redirects fetch
// to the trap vector. In every other state, WB CSR writes pass straight through.
module ysyx_22050550_trap_seq #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [63:0] wb_nextpc,
  input  logic [7:0]  wb_csren,
  input  logic [63:0] wb_mepc,
  input  logic [63:0] wb_mcause,
  input  logic [63:0] wb_mstatus,
  input  logic [63:0] mstatus,
  input  logic [63:0] mie,
  input  logic [63:0] mip,
  input  logic [63:0] mtvec,
  input  logic        pipe_empty,
  input  logic        redirect_ready,
  output logic [7:0]  csr_en,
  output logic [63:0] csr_mepc,
  output logic [63:0] csr_mcause,
  output logic [63:0] csr_mstatus,
  output logic        wb_ready,
  output logic        hold_fetch,
  output logic        flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [31:0] trap_cnt
);

  typedef enum logic [1:0] {IDLE, DRAIN, TRAP, REDIR} state_t;

  localparam logic [7:0]  TRAP_CSREN  = 8'b0000_1011;
  localparam logic [63:0] MCAUSE_MTI  = 64'h8000_0000_0000_0007;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] epc_q;
  logic [31:0] cnt_q;
  logic        first_redir_q;
  logic        pend;

  // mstatus image written on trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode.
  function automatic logic [63:0] trap_mstatus(input logic [63:0] ms);
    logic [63:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap target: vectored mode (mode 01) jumps to the MTI slot, cause 7 * 4.
  function automatic logic [63:0] trap_vector(input logic [63:0] tvec);
    logic [63:0] base;
    base = {tvec[63:2], 2'b00};
    return (tvec[1:0] == 2'b01) ? base + 64'd28 : base;
  endfunction

  assign pend = mip[7] & mie[7] & mstatus[3];

  // State, first-REDIR flag and trap counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      first_redir_q <= 1'b0;
      cnt_q         <= 32'd0;
    end else begin
      state_q       <= state_d;
      first_redir_q <= (state_q == TRAP);
      if (state_q == TRAP) cnt_q <= cnt_q + 32'd1;
    end
  end

  // Resume PC follows every accepted retirement, in any state.
  always_ff @(posedge clock) begin
    if (!reset) epc_q <= RESET_PC;
    else if (wb_valid && wb_ready) epc_q <= wb_nextpc;
  end

  // Next-state and output decode; trap write owns the CSR port only in TRAP.
  always_comb begin
    state_d        = state_q;
    csr_en         = wb_csren;
    csr_mepc       = wb_mepc;
    csr_mcause     = wb_mcause;
    csr_mstatus    = wb_mstatus;
    wb_ready       = 1'b1;
    hold_fetch     = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend) state_d = DRAIN;
      end
      DRAIN: begin
        hold_fetch = 1'b1;
        if (pipe_empty) state_d = pend ? TRAP : IDLE;
      end
      TRAP: begin
        wb_ready    = 1'b0;
        hold_fetch  = 1'b1;
        csr_en      = TRAP_CSREN;
        csr_mepc    = epc_q;
        csr_mcause  = MCAUSE_MTI;
        csr_mstatus = trap_mstatus(mstatus);
        state_d     = REDIR;
      end
      REDIR: begin
        hold_fetch     = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush       = first_redir_q;
  assign redirect_pc = trap_vector(mtvec);
  assign trap_cnt    = cnt_q;

endmodule
